router_pkt_reg: RTL and testbench

Parametrised packet register stage for the router datapath. It sits between the packet source and a destination FIFO, and runs its own packet FSM. It latches and decodes the header (destination and payload length), forwards every packet byte downstream in order, and absorbs destination back-pressure in a HOLD_DEPTH-entry hold buffer instead of a single register. It checks running XOR parity and payload length at the trailing parity byte.

---
 rtl/router_pkg.sv | 25 ++
 rtl/router_hold_fifo.sv | 55 +++++
 rtl/router_pkt_reg.sv | 175 +++++++++++++++++
 tb/tb_router_pkt_reg.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared state encoding, default parameters and header field
// helpers for the router packet register stage.
package router_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_ADDR_W     = 2;
    localparam int DEF_HOLD_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // Destination field: the low addr_w bits of the header byte.
    function automatic int hdr_dest(input int hdr, input int addr_w);
        return hdr & ((1 << addr_w) - 1);
    endfunction

    // Payload length field: everything above the destination field.
    function automatic int hdr_len(input int hdr, input int addr_w);
        return hdr >> addr_w;
    endfunction

endpackage

// File: rtl/router_hold_fifo.sv
// router_hold_fifo: DEPTH x DATA_W circular hold buffer. The head entry is
// visible on rd_data whenever count is non-zero. A write and a read in the
// same cycle leave count unchanged. The caller never writes when full and
// never reads when empty.
module router_hold_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Storage array: written at the tail, contents need no reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/router_pkt_reg.sv
// router_pkt_reg: packet register stage between the packet source and a
// destination FIFO. Decodes the header, forwards every byte in order through
// a hold buffer that absorbs destination back-pressure, and checks XOR
// parity (and optionally payload length) against the trailing parity byte.
// Build option: define ROUTER_LEN_CHECK_EN to enable the payload length
// check; when undefined len_err is tied low and the header upper bits are
// carried as opaque data.
//
// Source handshake: a byte on data_in is taken at a rising edge when busy is
// low. In IDLE the byte is a header only if pkt_valid is high; in PAYLOAD a
// byte is taken on every non-busy edge, pkt_valid high meaning payload and
// low meaning the parity byte. While busy is high the source holds data_in
// and pkt_valid. busy depends on registers only, so it is stable for the
// whole cycle. Downstream, dout_valid marks a byte written this cycle and is
// only produced for an edge at which fifo_full was low.
module router_pkt_reg
    import router_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int HOLD_DEPTH = DEF_HOLD_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    input  logic              fifo_full,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [ADDR_W-1:0] dest,
    output logic              dest_valid,
    output logic              parity_done,
    output logic              err,
    output logic              len_err,
    output logic              low_packet_valid
);

    localparam int CNT_W = $clog2(HOLD_DEPTH) + 1;

    state_t            state;
    state_t            state_nxt;
    logic              accept_hdr;
    logic              accept_pay;
    logic              accept_par;
    logic              accept;
    logic              buf_empty;
    logic              deq;
    logic              direct;
    logic              enq;
    logic [CNT_W-1:0]  buf_count;
    logic [DATA_W-1:0] buf_head;
    logic [DATA_W-1:0] parity;

    router_hold_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (HOLD_DEPTH)
    ) u_hold (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (enq),
        .wr_data (data_in),
        .rd_en   (deq),
        .rd_data (buf_head),
        .count   (buf_count)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: header opens a packet, parity byte closes it, and the
    // hold buffer must empty before the next header is taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_hdr) state_nxt = PAYLOAD;
            PAYLOAD: if (accept_par) state_nxt = DRAIN;
            DRAIN:   if (buf_empty)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: stall, byte-accept decode and hold-buffer steering.
    always_comb begin
        busy       = (buf_count == CNT_W'(HOLD_DEPTH)) || (state == DRAIN);
        accept_hdr = (state == IDLE)    &&  pkt_valid && !busy;
        accept_pay = (state == PAYLOAD) &&  pkt_valid && !busy;
        accept_par = (state == PAYLOAD) && !pkt_valid && !busy;
        accept     = accept_hdr || accept_pay || accept_par;
        buf_empty  = (buf_count == '0);
        deq        = !buf_empty && !fifo_full;
        // A new byte may bypass the buffer only when nothing older is queued.
        direct     = accept && buf_empty && !fifo_full;
        enq        = accept && !direct;
    end

    // Downstream byte register: queued bytes drain before any new byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (deq) begin
            dout       <= buf_head;
            dout_valid <= 1'b1;
        end else if (direct) begin
            dout       <= data_in;
            dout_valid <= 1'b1;
        end else begin
            dout_valid <= 1'b0;
        end
    end

    // Header decode, running parity and end-of-packet status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            dest             <= '0;
            dest_valid       <= 1'b0;
            parity           <= '0;
            parity_done      <= 1'b0;
            low_packet_valid <= 1'b0;
            err              <= 1'b0;
        end else begin
            dest_valid <= accept_hdr;
            if (accept_hdr) begin
                dest             <= ADDR_W'(hdr_dest(int'(data_in), ADDR_W));
                parity           <= data_in;
                parity_done      <= 1'b0;
                low_packet_valid <= 1'b0;
            end else if (accept_pay) begin
                parity <= parity ^ data_in;
            end else if (accept_par) begin
                parity_done      <= 1'b1;
                low_packet_valid <= 1'b1;
                err              <= (parity != data_in);
            end
        end
    end

`ifdef ROUTER_LEN_CHECK_EN
    localparam int LEN_W = DATA_W - ADDR_W;
    // Counter saturates at 2**LEN_W so it can never wrap back to a match.
    localparam logic [LEN_W:0] PAY_SAT = {1'b1, {LEN_W{1'b0}}};
    localparam logic [LEN_W:0] PAY_ONE = {{LEN_W{1'b0}}, 1'b1};

    logic [LEN_W-1:0] len_q;
    logic [LEN_W:0]   pay_cnt;

    // Payload counter and length comparison at the parity byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            len_q   <= '0;
            pay_cnt <= '0;
            len_err <= 1'b0;
        end else if (accept_hdr) begin
            len_q   <= LEN_W'(hdr_len(int'(data_in), ADDR_W));
            pay_cnt <= '0;
        end else if (accept_pay) begin
            if (pay_cnt != PAY_SAT) begin
                pay_cnt <= pay_cnt + PAY_ONE;
            end
        end else if (accept_par) begin
            len_err <= (pay_cnt != {1'b0, len_q});
        end
    end
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_pkt_reg.sv
// tb_router_pkt_reg: directed plus randomized packets against a queue-based
// reference of the byte stream and packet status.
module tb_router_pkt_reg;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 2;
    localparam int HOLD_DEPTH = 4;
    localparam int LEN_W      = DATA_W - ADDR_W;
    localparam int MAX_WAIT   = 1000;

    logic              clock = 1'b0;
    logic              reset;
    logic              pkt_valid;
    logic [DATA_W-1:0] data_in;
    logic              busy;
    logic              fifo_full;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic [ADDR_W-1:0] dest;
    logic              dest_valid;
    logic              parity_done;
    logic              err;
    logic              len_err;
    logic              low_packet_valid;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] pkt_q[$];

    int   ff_mode       = 0;
    int   dv_cnt        = 0;
    int   stall_release = 0;
    logic stall_fired   = 1'b0;
    logic last_err      = 1'b0;
    logic last_len_err  = 1'b0;

    router_pkt_reg #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .HOLD_DEPTH (HOLD_DEPTH)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .busy             (busy),
        .fifo_full        (fifo_full),
        .dout             (dout),
        .dout_valid       (dout_valid),
        .dest             (dest),
        .dest_valid       (dest_valid),
        .parity_done      (parity_done),
        .err              (err),
        .len_err          (len_err),
        .low_packet_valid (low_packet_valid)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // fifo_full pattern: 0 low, 1 held high, 2 toggling, 3 random.
    task automatic apply_ff();
        case (ff_mode)
            0:       fifo_full = 1'b0;
            1:       fifo_full = 1'b1;
            2:       fifo_full = ~fifo_full;
            default: fifo_full = 1'($urandom_range(0, 1));
        endcase
    endtask

    // One clock; outputs are sampled 1ns after the edge, then the scoreboard
    // consumes any emitted byte.
    task automatic tick();
        logic ff_prev;
        ff_prev = fifo_full;
        @(posedge clock);
        #1;
        if (dout_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("dout_extra_valid", dout_valid, 0);
            else                   chk("dout_order", dout, exp_q.pop_front());
        end
        if (ff_prev) chk("dout_while_full", dout_valid, 0);
        chk("hold_occupancy", exp_q.size() <= HOLD_DEPTH, 1);
        if (dest_valid === 1'b1) dv_cnt++;
        apply_ff();
    endtask

    task automatic build_pkt(input int d, input int len, input int n_pay, input bit corrupt);
        logic [7:0] x;
        logic [7:0] b;
        pkt_q.delete();
        b = {6'(len), 2'(d)};
        pkt_q.push_back(b);
        x = b;
        for (int i = 0; i < n_pay; i++) begin
            b = 8'($urandom);
            pkt_q.push_back(b);
            x ^= b;
        end
        if (corrupt) x ^= 8'($urandom_range(1, 255));
        pkt_q.push_back(x);
    endtask

    // Drive pkt_q as one packet; expected status comes from the bytes alone.
    task automatic send_pkt(input bit strict);
        logic [7:0] hdr;
        logic [7:0] par_calc;
        logic [7:0] par_byte;
        logic       exp_err;
        logic       exp_len_err;
        int         n_pay;
        int         wait_cnt;
        int         last;
        hdr      = pkt_q[0];
        last     = pkt_q.size() - 1;
        par_byte = pkt_q[last];
        n_pay    = pkt_q.size() - 2;
        par_calc = '0;
        for (int i = 0; i < last; i++) par_calc ^= pkt_q[i];
        exp_err = (par_calc != par_byte);
`ifdef ROUTER_LEN_CHECK_EN
        begin
            int sat;
            sat = (n_pay > (1 << LEN_W)) ? (1 << LEN_W) : n_pay;
            exp_len_err = (sat != int'(hdr[7:2]));
        end
`else
        exp_len_err = (n_pay < 0);
`endif
        dv_cnt      = 0;
        stall_fired = 1'b0;
        for (int i = 0; i <= last; i++) begin
            data_in   = pkt_q[i];
            pkt_valid = (i != last);
            wait_cnt  = 0;
            while (busy !== 1'b0 && wait_cnt < MAX_WAIT) begin
                if (stall_release != 0 && wait_cnt == stall_release) begin
                    chk("bytes_before_stall", i, HOLD_DEPTH);
                    stall_fired = 1'b1;
                    ff_mode     = 0;
                    fifo_full   = 1'b0;
                end
                tick();
                wait_cnt++;
            end
            if (wait_cnt >= MAX_WAIT) begin
                chk("accept_timeout", busy, 0);
                pkt_valid = 1'b0;
                return;
            end
            exp_q.push_back(pkt_q[i]);
            tick();
            if (strict) chk("direct_latency", exp_q.size(), 0);
            if (i == 0) begin
                chk("dest_valid_pulse", dest_valid, 1);
                chk("dest_decode", dest, hdr[1:0]);
                chk("parity_done_cleared", parity_done, 0);
                chk("lpv_cleared", low_packet_valid, 0);
                chk("err_held", err, last_err);
                chk("len_err_held", len_err, last_len_err);
            end
            if (i == last) chk("drain_busy", busy, 1);
        end
        pkt_valid = 1'b0;
        data_in   = 8'($urandom);
        wait_cnt  = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && wait_cnt < MAX_WAIT) begin
            tick();
            wait_cnt++;
        end
        chk("drained", exp_q.size(), 0);
        chk("idle_not_busy", busy, 0);
        chk("dest_valid_count", dv_cnt, 1);
        chk("parity_done", parity_done, 1);
        chk("low_packet_valid", low_packet_valid, 1);
        chk("err", err, exp_err);
        chk("len_err", len_err, exp_len_err);
        chk("dest_held", dest, hdr[1:0]);
        last_err     = exp_err;
        last_len_err = exp_len_err;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dout"}, dout, 0);
        chk({tag, "_dout_valid"}, dout_valid, 0);
        chk({tag, "_dest"}, dest, 0);
        chk({tag, "_dest_valid"}, dest_valid, 0);
        chk({tag, "_parity_done"}, parity_done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_len_err"}, len_err, 0);
        chk({tag, "_lpv"}, low_packet_valid, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        // Reset state
        reset     = 1'b1;
        pkt_valid = 1'b0;
        data_in   = '0;
        fifo_full = 1'b0;
        ff_mode   = 0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Basic packet: XOR of header and payload is 0x0D.
        pkt_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        send_pkt(1'b1);
        chk("pkt1_dest", dest, 1);
        chk("pkt1_err", err, 0);
        chk("pkt1_len_err", len_err, 0);

        // Wrong parity byte.
        pkt_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
        send_pkt(1'b1);
        chk("pkt2_err", err, 1);
        chk("pkt2_len_err", len_err, 0);

        // Header says 3 payload bytes, only 2 sent, parity correct.
        pkt_q = '{8'h0D, 8'h11, 8'h22, 8'h3E};
        send_pkt(1'b1);
        chk("pkt3_err", err, 0);
`ifdef ROUTER_LEN_CHECK_EN
        chk("pkt3_len_err", len_err, 1);
`else
        chk("pkt3_len_err", len_err, 0);
`endif

        // Zero-length packet.
        pkt_q = '{8'h01, 8'h01};
        send_pkt(1'b1);
        chk("zero_len_err", len_err, 0);
        chk("zero_len_parity", err, 0);

        // Back-pressure: fifo_full held high through a 6-byte packet.
        ff_mode       = 1;
        fifo_full     = 1'b1;
        stall_release = 3;
        build_pkt(2, 4, 4, 1'b0);
        send_pkt(1'b0);
        stall_release = 0;
        chk("stall_seen", stall_fired, 1);

        // fifo_full toggling every cycle.
        ff_mode = 2;
        build_pkt(3, 5, 5, 1'b0);
        send_pkt(1'b0);
        ff_mode   = 0;
        fifo_full = 1'b0;

        // Payload counter saturation and largest length field.
        build_pkt(0, 0, 128, 1'b0);
        send_pkt(1'b1);
        build_pkt(3, 63, 63, 1'b0);
        send_pkt(1'b1);
        chk("len63_len_err", len_err, 0);

        // Reset mid-payload with bytes held in the buffer.
        ff_mode   = 1;
        fifo_full = 1'b1;
        build_pkt(1, 3, 3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("pre_reset_not_busy", busy, 0);
            data_in   = pkt_q[i];
            pkt_valid = 1'b1;
            exp_q.push_back(pkt_q[i]);
            tick();
        end
        reset     = 1'b1;
        pkt_valid = 1'b0;
        ff_mode   = 0;
        fifo_full = 1'b0;
        tick();
        check_all_zero("mid_reset");
        exp_q.delete();
        reset        = 1'b0;
        last_err     = 1'b0;
        last_len_err = 1'b0;
        tick();
        pkt_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        send_pkt(1'b1);
        chk("post_reset_err", err, 0);

        // Randomized packets with random back-pressure.
        for (int k = 0; k < 20; k++) begin
            int len;
            int n;
            ff_mode = 3;
            len = $urandom_range(0, 6);
            case ($urandom_range(0, 3))
                0:       n = len + 1;
                1:       n = (len > 0) ? len - 1 : len;
                default: n = len;
            endcase
            build_pkt($urandom_range(0, 3), len, n, $urandom_range(0, 3) == 0);
            send_pkt(1'b0);
        end
        ff_mode   = 0;
        fifo_full = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit in case a wait loop is ever unbounded.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
